// File: rtl/texfetch_pkg.sv
// Shared constants, texel layout and FSM encoding for the bilinear texel fetch front end.
package texfetch_pkg;

  localparam int unsigned CHANNELS   = 4;
  localparam int unsigned CH_W       = 8;
  localparam int unsigned FRACT_BITS = 8;
  localparam int unsigned TEX_W_LOG2 = 8;
  localparam int unsigned TEX_H_LOG2 = 8;
  localparam int unsigned ADDR_W     = TEX_W_LOG2 + TEX_H_LOG2;
  localparam int unsigned TEXEL_W    = CHANNELS * CH_W;
  localparam int unsigned U_W        = TEX_W_LOG2 + FRACT_BITS;
  localparam int unsigned V_W        = TEX_H_LOG2 + FRACT_BITS;
  localparam int unsigned CNT_W      = 3;
  localparam int unsigned QUAD_N     = 4;

  // Channel i of a texel lives at [(i+1)*CH_W-1 -: CH_W].
  typedef logic [TEXEL_W-1:0] texel_t;

  // Texel address layout: row index above column index.
  typedef struct packed {
    logic [TEX_H_LOG2-1:0] y;
    logic [TEX_W_LOG2-1:0] x;
  } texaddr_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_OUT   = 2'd2
  } state_e;

  // Extract one channel from a packed texel.
  function automatic logic [CH_W-1:0] texel_chan(input texel_t t, input int unsigned idx);
    return t[idx*CH_W +: CH_W];
  endfunction

endpackage

// File: rtl/bilinear_addr_gen.sv
// Combinational coordinate split, neighbour computation and footprint address mux.
// Build option: define CLAMP_ADDR_EN for clamp-to-edge neighbours (default wraps).
module bilinear_addr_gen
  import texfetch_pkg::*;
(
  input  logic [U_W-1:0]        u_i,
  input  logic [V_W-1:0]        v_i,
  input  logic [1:0]            sel_i,
  output logic [FRACT_BITS-1:0] fx_c,
  output logic [FRACT_BITS-1:0] fy_c,
  output logic [ADDR_W-1:0]     addr_c
);

  logic [TEX_W_LOG2-1:0] x0, x1;
  logic [TEX_H_LOG2-1:0] y0, y1;
  texaddr_t              sel_addr;

  assign x0   = u_i[U_W-1:FRACT_BITS];
  assign y0   = v_i[V_W-1:FRACT_BITS];
  assign fx_c = u_i[FRACT_BITS-1:0];
  assign fy_c = v_i[FRACT_BITS-1:0];

`ifdef CLAMP_ADDR_EN
  // Right/lower neighbour stops at the last texel.
  assign x1 = (x0 == {TEX_W_LOG2{1'b1}}) ? x0 : x0 + TEX_W_LOG2'(1);
  assign y1 = (y0 == {TEX_H_LOG2{1'b1}}) ? y0 : y0 + TEX_H_LOG2'(1);
`else
  // Right/lower neighbour wraps around the power-of-two texture.
  assign x1 = x0 + TEX_W_LOG2'(1);
  assign y1 = y0 + TEX_H_LOG2'(1);
`endif

  // Footprint order: 00, 10, 01, 11 (bit 0 picks x1, bit 1 picks y1).
  always_comb begin
    sel_addr.x = sel_i[0] ? x1 : x0;
    sel_addr.y = sel_i[1] ? y1 : y0;
  end

  assign addr_c = sel_addr;

endmodule

// File: rtl/bilinear_texel_fetch.sv
// Bilinear texel fetch: splits (u,v), issues the 2x2 footprint reads, collects the
// in-order responses and hands the quad plus fx/fy to the filter.
// Build option: CLAMP_ADDR_EN selects clamp-to-edge neighbours instead of wrap.
module bilinear_texel_fetch
  import texfetch_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [U_W-1:0]        u,
  input  logic [V_W-1:0]        v,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [ADDR_W-1:0]     mem_addr,
  input  logic                  mem_rsp_valid,
  input  texel_t                mem_rsp_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output texel_t                texel00,
  output texel_t                texel10,
  output texel_t                texel01,
  output texel_t                texel11,
  output logic [FRACT_BITS-1:0] fx,
  output logic [FRACT_BITS-1:0] fy
);

  state_e                    state_q, state_d;
  logic [CNT_W-1:0]          req_cnt_q, req_cnt_d;
  logic [CNT_W-1:0]          rsp_cnt_q, rsp_cnt_d;
  logic [U_W-1:0]            u_q, u_d;
  logic [V_W-1:0]            v_q, v_d;
  logic [FRACT_BITS-1:0]     fx_q, fx_d, fy_q, fy_d;
  logic [QUAD_N-1:0][TEXEL_W-1:0] slot_q, slot_d;
  logic                      mem_req_valid_q, mem_req_valid_d;
  logic [ADDR_W-1:0]         mem_addr_q, mem_addr_d;
  logic                      out_valid_q, out_valid_d;
  logic                      in_ready_q, in_ready_d;

  logic                      accept_c, req_hs_c, rsp_take_c;
  logic [1:0]                sel_c;
  logic [U_W-1:0]            coord_u_c;
  logic [V_W-1:0]            coord_v_c;
  logic [FRACT_BITS-1:0]     fx_c, fy_c;
  logic [ADDR_W-1:0]         addr_c;

  assign accept_c = in_valid && in_ready_q;
  assign req_hs_c = mem_req_valid_q && mem_req_ready;
  // A request handshaking this cycle counts as outstanding (zero-latency memory).
  assign rsp_take_c = mem_rsp_valid && (state_q == ST_FETCH) &&
                      (rsp_cnt_q < (req_cnt_q + CNT_W'(req_hs_c)));

  // Address for the request presented next cycle; raw coordinate while idle.
  assign coord_u_c = (state_q == ST_IDLE) ? u : u_q;
  assign coord_v_c = (state_q == ST_IDLE) ? v : v_q;
  assign sel_c     = (state_q == ST_IDLE) ? 2'd0 :
                     (req_hs_c ? req_cnt_q[1:0] + 2'd1 : req_cnt_q[1:0]);

  bilinear_addr_gen u_addr_gen (
    .u_i    (coord_u_c),
    .v_i    (coord_v_c),
    .sel_i  (sel_c),
    .fx_c   (fx_c),
    .fy_c   (fy_c),
    .addr_c (addr_c)
  );

  // Next-state and registered-output computation.
  always_comb begin
    state_d         = state_q;
    req_cnt_d       = req_cnt_q;
    rsp_cnt_d       = rsp_cnt_q;
    u_d             = u_q;
    v_d             = v_q;
    fx_d            = fx_q;
    fy_d            = fy_q;
    slot_d          = slot_q;
    mem_req_valid_d = mem_req_valid_q;
    mem_addr_d      = mem_addr_q;
    out_valid_d     = out_valid_q;
    in_ready_d      = in_ready_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          u_d             = u;
          v_d             = v;
          fx_d            = fx_c;
          fy_d            = fy_c;
          req_cnt_d       = '0;
          rsp_cnt_d       = '0;
          mem_req_valid_d = 1'b1;
          mem_addr_d      = addr_c;
          in_ready_d      = 1'b0;
          state_d         = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (req_hs_c) begin
          req_cnt_d = req_cnt_q + CNT_W'(1);
          if (req_cnt_q == CNT_W'(QUAD_N - 1)) begin
            mem_req_valid_d = 1'b0;
          end else begin
            mem_addr_d = addr_c;
          end
        end
        if (rsp_take_c) begin
          slot_d[rsp_cnt_q[1:0]] = mem_rsp_data;
          rsp_cnt_d              = rsp_cnt_q + CNT_W'(1);
          if (rsp_cnt_q == CNT_W'(QUAD_N - 1)) begin
            out_valid_d = 1'b1;
            state_d     = ST_OUT;
          end
        end
      end
      ST_OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_IDLE;
      req_cnt_q       <= '0;
      rsp_cnt_q       <= '0;
      u_q             <= '0;
      v_q             <= '0;
      fx_q            <= '0;
      fy_q            <= '0;
      slot_q          <= '0;
      mem_req_valid_q <= 1'b0;
      mem_addr_q      <= '0;
      out_valid_q     <= 1'b0;
      in_ready_q      <= 1'b1;
    end else begin
      state_q         <= state_d;
      req_cnt_q       <= req_cnt_d;
      rsp_cnt_q       <= rsp_cnt_d;
      u_q             <= u_d;
      v_q             <= v_d;
      fx_q            <= fx_d;
      fy_q            <= fy_d;
      slot_q          <= slot_d;
      mem_req_valid_q <= mem_req_valid_d;
      mem_addr_q      <= mem_addr_d;
      out_valid_q     <= out_valid_d;
      in_ready_q      <= in_ready_d;
    end
  end

  // Flag responses that arrive with nothing outstanding; they are dropped.
  always @(posedge clk) begin
    if (rst_n) begin
      assert (!(mem_rsp_valid && !rsp_take_c))
        else $warning("bilinear_texel_fetch: response with no request outstanding dropped");
    end
  end

  assign in_ready      = in_ready_q;
  assign mem_req_valid = mem_req_valid_q;
  assign mem_addr      = mem_addr_q;
  assign out_valid     = out_valid_q;
  assign texel00       = slot_q[0];
  assign texel10       = slot_q[1];
  assign texel01       = slot_q[2];
  assign texel11       = slot_q[3];
  assign fx            = fx_q;
  assign fy            = fy_q;

endmodule

// File: tb/tb_bilinear_texel_fetch.sv
// Self-checking bench for bilinear_texel_fetch with a behavioural memory and quad model.
module tb_bilinear_texel_fetch;
  import texfetch_pkg::*;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [U_W-1:0]  u = '0;
  logic [V_W-1:0]  v = '0;
  logic            mem_req_valid;
  logic            mem_req_ready = 1'b0;
  logic [ADDR_W-1:0] mem_addr;
  logic            mem_rsp_valid = 1'b0;
  texel_t          mem_rsp_data = '0;
  logic            out_valid;
  logic            out_ready = 1'b1;
  texel_t          texel00, texel10, texel01, texel11;
  logic [FRACT_BITS-1:0] fx, fy;

  int unsigned     n_tests = 0;
  int unsigned     n_fail  = 0;

  // Memory model controls and request log.
  int              rdy_mode = 0;     // 0: always ready, 1: toggle, 2: random
  bit              lat0 = 1'b0;      // 1: respond in the handshake cycle
  bit              spur_req = 1'b0;
  bit              pend_v = 1'b0;
  logic [15:0]     pend_a = '0;
  bit              stall_prev = 1'b0;
  logic [15:0]     stall_addr = '0;
  logic [15:0]     issued[$];

  bilinear_texel_fetch dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .u             (u),
    .v             (v),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_addr      (mem_addr),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_data  (mem_rsp_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .texel00       (texel00),
    .texel10       (texel10),
    .texel01       (texel01),
    .texel11       (texel11),
    .fx            (fx),
    .fy            (fy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] tex_data(input logic [15:0] a);
    return {~a, a};
  endfunction

  // Reference address of footprint entry k (0:00, 1:10, 2:01, 3:11).
  function automatic logic [15:0] exp_addr(input logic [15:0] uu, input logic [15:0] vv, input int k);
    int x0, y0, x1, y1, xs, ys;
    x0 = int'(uu) / 256;
    y0 = int'(vv) / 256;
`ifdef CLAMP_ADDR_EN
    x1 = (x0 + 1 > 255) ? 255 : x0 + 1;
    y1 = (y0 + 1 > 255) ? 255 : y0 + 1;
`else
    x1 = (x0 + 1) % 256;
    y1 = (y0 + 1) % 256;
`endif
    xs = (k % 2 == 1) ? x1 : x0;
    ys = (k / 2 == 1) ? y1 : y0;
    return 16'(ys * 256 + xs);
  endfunction

  // Memory: drives ready/response on the falling edge, logs handshakes.
  always @(negedge clk) begin
    bit r, hs;
    if (!rst_n) begin
      mem_rsp_valid = 1'b0;
      mem_req_ready = 1'b0;
      pend_v        = 1'b0;
      stall_prev    = 1'b0;
    end else begin
      if (stall_prev) begin
        check("addr_hold_stall", 32'(mem_addr), 32'(stall_addr));
        check("valid_hold_stall", 32'(mem_req_valid), 32'd1);
      end
      case (rdy_mode)
        0:       r = 1'b1;
        1:       r = ~mem_req_ready;
        default: r = 1'($urandom_range(0, 1));
      endcase
      mem_req_ready = r;
      hs            = mem_req_valid && r;
      stall_prev    = mem_req_valid && !r;
      stall_addr    = mem_addr;
      if (hs) issued.push_back(mem_addr);
      if (lat0) begin
        mem_rsp_valid = hs;
        mem_rsp_data  = tex_data(mem_addr);
      end else begin
        mem_rsp_valid = pend_v;
        mem_rsp_data  = tex_data(pend_a);
        pend_v        = hs;
        pend_a        = mem_addr;
      end
      if (spur_req) begin
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'hDEAD_BEEF;
        spur_req      = 1'b0;
      end
    end
  end

  task automatic check_quad(input string tag, input logic [15:0] uu, input logic [15:0] vv);
    check({tag, "_t00"}, texel00, tex_data(exp_addr(uu, vv, 0)));
    check({tag, "_t10"}, texel10, tex_data(exp_addr(uu, vv, 1)));
    check({tag, "_t01"}, texel01, tex_data(exp_addr(uu, vv, 2)));
    check({tag, "_t11"}, texel11, tex_data(exp_addr(uu, vv, 3)));
    check({tag, "_fx"}, 32'(fx), 32'(uu[7:0]));
    check({tag, "_fy"}, 32'(fy), 32'(vv[7:0]));
  endtask

  // One coordinate through the block; optional output stall with a spurious response.
  task automatic run_quad(input logic [15:0] uu, input logic [15:0] vv, input int stall, input bit chk_lat);
    int n;
    logic [15:0] a;
    issued.delete();
    @(negedge clk);
    check("in_ready_idle", 32'(in_ready), 32'd1);
    u = uu; v = vv; in_valid = 1'b1; out_ready = (stall == 0);
    @(negedge clk);
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("out_valid_seen", 32'(out_valid), 32'd1);
    if (chk_lat) check("latency", 32'(n), 32'd6);
    check("req_count", 32'(issued.size()), 32'd4);
    for (int k = 0; k < 4; k++) begin
      a = (k < issued.size()) ? issued[k] : 16'hxxxx;
      check($sformatf("req_addr%0d", k), 32'(a), 32'(exp_addr(uu, vv, k)));
    end
    check_quad("quad", uu, vv);
    if (stall > 0) begin
      for (int i = 0; i < stall; i++) begin
        in_valid = 1'b1; u = ~uu; v = ~vv;
        if (i == 2) spur_req = 1'b1;
        @(negedge clk);
        check("stall_in_ready", 32'(in_ready), 32'd0);
        check("stall_out_valid", 32'(out_valid), 32'd1);
        check("stall_t00", texel00, tex_data(exp_addr(uu, vv, 0)));
      end
      check_quad("held", uu, vv);
      in_valid = 1'b0; out_ready = 1'b1;
    end
    @(negedge clk);
    check("post_out_valid", 32'(out_valid), 32'd0);
    check("post_in_ready", 32'(in_ready), 32'd1);
    check("post_req_valid", 32'(mem_req_valid), 32'd0);
    check("post_req_count", 32'(issued.size()), 32'd4);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_req_valid"}, 32'(mem_req_valid), 32'd0);
    check({tag, "_addr"}, 32'(mem_addr), 32'd0);
    check({tag, "_t00"}, texel00, 32'd0);
    check({tag, "_t10"}, texel10, 32'd0);
    check({tag, "_fx"}, 32'(fx), 32'd0);
    check({tag, "_fy"}, 32'(fy), 32'd0);
  endtask

  initial begin
    int n;
    logic [15:0] ru, rv;
    int st;
    repeat (3) @(negedge clk);
    #1 check_reset_state("reset");
    #1 rst_n = 1'b1;

    rdy_mode = 0; lat0 = 1'b0;
    run_quad(16'h0340, 16'h0280, 0, 1'b1);
    run_quad(16'hFF80, 16'hFF10, 0, 1'b1);

    rdy_mode = 1;
    run_quad(16'h1A2B, 16'h3C4D, 0, 1'b0);

    rdy_mode = 0;
    run_quad(16'h7F01, 16'h00FE, 10, 1'b0);

    lat0 = 1'b1;
    run_quad(16'h5566, 16'h7788, 0, 1'b0);
    rdy_mode = 1;
    run_quad(16'hFFFF, 16'h0000, 3, 1'b0);

    // Asynchronous reset once two requests have gone out.
    rdy_mode = 0; lat0 = 1'b0;
    issued.delete();
    @(negedge clk);
    u = 16'h1234; v = 16'h5678; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (issued.size() < 2 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("reset_reach_fetch", 32'(issued.size() >= 2), 32'd1);
    #2 rst_n = 1'b0;
    #1 check_reset_state("midreset");
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
    run_quad(16'h4321, 16'h8765, 0, 1'b1);

    for (int i = 0; i < 16; i++) begin
      rdy_mode = int'($urandom_range(0, 2));
      lat0     = 1'($urandom_range(0, 1));
      ru       = 16'($urandom);
      rv       = 16'($urandom);
      st       = ($urandom_range(0, 3) == 0) ? int'($urandom_range(3, 6)) : 0;
      run_quad(ru, rv, st, (rdy_mode == 0) && !lat0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule

// File: doc/bilinear_texel_fetch.md
Name: bilinear_texel_fetch

Overview:
Front end that feeds the team's bilinear filter stage. It accepts a texel-space (u,v) coordinate, splits it into integer texel indices and fractional weights, and issues four reads for the 2x2 footprint to the texture memory port. It collects the four in-order responses and presents the quad plus fx/fy to the filter over a valid/ready handshake.

Parameters:
CHANNELS, 4, channels per texel
CH_W, 8, bits per channel
FRACT_BITS, 8, fractional bits of u/v; also the width of fx/fy (Q0.F)
TEX_W_LOG2, 8, log2 of texture width in texels (power-of-two textures only)
TEX_H_LOG2, 8, log2 of texture height in texels
ADDR_W, TEX_W_LOG2+TEX_H_LOG2, texel address width (localparam)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  coordinate valid
in_ready  out  1  block can accept a coordinate
u  in  TEX_W_LOG2+FRACT_BITS  texel-space x, unsigned Q(TEX_W_LOG2).FRACT_BITS
v  in  TEX_H_LOG2+FRACT_BITS  texel-space y, unsigned Q(TEX_H_LOG2).FRACT_BITS
mem_req_valid  out  1  read request valid
mem_req_ready  in  1  memory accepts request
mem_addr  out  ADDR_W  texel address = {y, x}
mem_rsp_valid  in  1  read data valid; in order, one per request, no backpressure
mem_rsp_data  in  CHANNELS*CH_W  texel data
out_valid  out  1  quad valid to filter
out_ready  in  1  filter accepts quad
texel00, texel10, texel01, texel11  out  CHANNELS*CH_W each  texels at (x0,y0), (x1,y0), (x0,y1), (x1,y1)
fx, fy  out  FRACT_BITS each  fractional weights

Behaviour:
- Reset (async assert, sync release): in_ready=1, out_valid=0, mem_req_valid=0, mem_addr=0, all texel outputs and fx/fy = 0, FSM in IDLE, counters cleared.
- FSM IDLE -> FETCH -> OUT -> IDLE.
- IDLE: in_ready=1. On in_valid&&in_ready, register x0=u[hi], fx=u[FRACT_BITS-1:0], y0=v[hi], fy=v[lo]. Set x1=x0+1 and y1=y0+1 modulo 2^TEX_W_LOG2 / 2^TEX_H_LOG2 (wrap addressing). Go to FETCH. in_ready=0 in every other state.
- FETCH: requests issued in the fixed order 00, 10, 01, 11 using a 3-bit req_cnt. mem_req_valid=1 while req_cnt<4. mem_addr is stable while valid&&!ready. req_cnt advances only on mem_req_valid&&mem_req_ready. The first request is valid the cycle after acceptance.
- Responses: a 3-bit rsp_cnt steers mem_rsp_data into slot rsp_cnt. Responses may arrive in the same cycle as a request handshake, including the zero-latency case. A response with rsp_cnt==req_cnt (none outstanding) is ignored and does not advance rsp_cnt (simulation assertion fires). When rsp_cnt reaches 4, go to OUT.
- OUT: out_valid=1. Outputs are registered and held stable until out_ready. On out_valid&&out_ready, out_valid=0 next cycle and return to IDLE (in_ready=1 next cycle).
- Best-case latency, acceptance to out_valid, is 6 cycles with mem_req_ready=1 and 1-cycle memory. There is no overlap between quads.
- Reset mid-operation: everything is discarded; late responses are the memory's responsibility, since it shares rst_n.

Optional Feature:
CLAMP_ADDR_EN: when defined, x1=min(x0+1, 2^TEX_W_LOG2-1) and y1=min(y0+1, 2^TEX_H_LOG2-1) (clamp-to-edge). fx/fy are unchanged. When undefined, wrap addressing as above.

Decomposition:
- Shared package texfetch_pkg: CHANNELS, CH_W, FRACT_BITS, the texel packing layout (channel i at [(i+1)*CH_W-1 -: CH_W]), and the FSM state encoding.
- Sub-module bilinear_addr_gen (combinational, purely): coordinate split, neighbour computation (wrap/clamp), and the 4-entry address mux indexed by req_cnt.

Test Plan:
- Basic quad: u=0x0340, v=0x0280, mem_req_ready=1, 1-cycle memory returning data=addr. Addresses 0x0203, 0x0204, 0x0303, 0x0304 in order; fx=0x40, fy=0x80; out_valid at cycle 6.
- Wrap edge: u=0xFF80, v=0xFF10. Addresses 0xFFFF, 0xFF00, 0x00FF, 0x0000. With CLAMP_ADDR_EN: 0xFFFF for all four.
- Memory backpressure: mem_req_ready toggled 0/1 each cycle. mem_addr stays stable while stalled, exactly 4 requests are issued, and slot data is correct.
- Output stall: out_ready=0 for 10 cycles. Outputs hold, in_ready stays 0, and a second in_valid is not accepted until the cycle after out_ready=1.
- Zero-latency and spurious responses: rsp_valid in the same cycle as each request is captured correctly. An extra rsp_valid in OUT is ignored and triggers the assertion.
- Async reset in FETCH after 2 requests: all outputs return to reset values immediately. A new coordinate after release produces a correct quad.
